// File: rtl/shift_register_pkg.sv
// Shared mode encoding for the serial-load stimulus array and its channels.
package shift_register_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_HOLD   = 2'b00;
  localparam mode_t MODE_SHIFT  = 2'b01;
  localparam mode_t MODE_ROTATE = 2'b10;
  localparam mode_t MODE_CLEAR  = 2'b11;

endpackage

// File: rtl/compressor.sv
// Column compressor under test: reduces the NCH channel words of the flat
// window to their arithmetic sum, NDST bits wide.
module compressor #(
  parameter int NCH   = 31,
  parameter int DEPTH = 31,
  parameter int NDST  = 36
) (
  input  logic [NCH*DEPTH-1:0] src,
  output logic [NDST-1:0]      dst
);

  logic [NDST-1:0] acc;

  always_comb begin
    acc = '0;
    for (int c = 0; c < NCH; c++) begin
      acc = acc + NDST'(src[c*DEPTH +: DEPTH]);
    end
  end

  assign dst = acc;

endmodule

// File: rtl/shift_register_array_sr_channel.sv
// One channel of the stimulus array: a DEPTH-bit register with hold, serial
// shift-in at the LSB, rotate-left and synchronous clear.
module sr_channel
  import shift_register_pkg::*;
#(
  parameter int DEPTH = 31
) (
  input  logic             clk,
  input  logic             rst,
  input  mode_t            mode,
  input  logic             src_bit,
  output logic [DEPTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else begin
      case (mode)
        MODE_SHIFT:  q <= {q[DEPTH-2:0], src_bit};
        MODE_ROTATE: q <= {q[DEPTH-2:0], q[DEPTH-1]};
        MODE_CLEAR:  q <= '0;
        default:     q <= q;
      endcase
    end
  end

endmodule

// File: rtl/shift_register_array.sv
// Serial-load stimulus array: NCH shift registers feed the compressor, whose
// result is captured each cycle along with a flag marking a fully loaded window.
module shift_register_array
  import shift_register_pkg::*;
#(
  parameter  int NCH   = 31,
  parameter  int DEPTH = 31,
  parameter  int NDST  = 36,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NCH-1:0]  src_,
  input  mode_t           mode,
  output logic [CW-1:0]   fill,
  output logic            full,
  output logic [NDST-1:0] dst,
  output logic            dst_valid
);

  logic [NCH*DEPTH-1:0] window;
  logic [NDST-1:0]      comp_dst;

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    sr_channel #(.DEPTH(DEPTH)) u_chan (
      .clk     (clk),
      .rst     (rst),
      .mode    (mode),
      .src_bit (src_[c]),
      .q       (window[c*DEPTH +: DEPTH])
    );
  end

  compressor #(.NCH(NCH), .DEPTH(DEPTH), .NDST(NDST)) u_compressor (
    .src (window),
    .dst (comp_dst)
  );

  assign full = (fill == CW'(DEPTH));

  // Fill saturates at DEPTH; ROTATE only reorders bits already loaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill <= '0;
    end else begin
      case (mode)
        MODE_SHIFT: if (!full) fill <= fill + CW'(1);
        MODE_CLEAR: fill <= '0;
        default:    fill <= fill;
      endcase
    end
  end

  // CLEAR gates the flag so it drops on the same edge the window is wiped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dst       <= '0;
      dst_valid <= 1'b0;
    end else begin
      dst       <= comp_dst;
      dst_valid <= full && (mode != MODE_CLEAR);
    end
  end

endmodule

// File: tb/tb_shift_register_array.sv
// Bench for shift_register_array: a 4x4 instance for directed scenarios and a
// default 31x31 instance driven randomly against a word-level reference model.
module tb_shift_register_array;

  localparam logic [1:0] M_HOLD   = 2'b00;
  localparam logic [1:0] M_SHIFT  = 2'b01;
  localparam logic [1:0] M_ROTATE = 2'b10;
  localparam logic [1:0] M_CLEAR  = 2'b11;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // small instance: NCH=4, DEPTH=4, NDST=6
  logic [3:0] src_s  = '0;
  logic [1:0] mode_s = M_HOLD;
  logic [2:0] fill_s;
  logic       full_s;
  logic [5:0] dst_s;
  logic       dst_valid_s;

  // default instance: 31x31, NDST=36
  logic [30:0] src_d  = '0;
  logic [1:0]  mode_d = M_HOLD;
  logic [4:0]  fill_d;
  logic        full_d;
  logic [35:0] dst_d;
  logic        dst_valid_d;

  int total = 0;
  int bad   = 0;

  logic [36:0] exp_q[$];

  shift_register_array #(.NCH(4), .DEPTH(4), .NDST(6)) dut_s (
    .clk(clk), .rst(rst), .src_(src_s), .mode(mode_s),
    .fill(fill_s), .full(full_s), .dst(dst_s), .dst_valid(dst_valid_s)
  );

  shift_register_array dut_d (
    .clk(clk), .rst(rst), .src_(src_d), .mode(mode_d),
    .fill(fill_d), .full(full_d), .dst(dst_d), .dst_valid(dst_valid_d)
  );

  // driver: apply inputs to the small instance, then sample 1ns after the edge
  task automatic step_s(input logic [1:0] m, input logic [3:0] s);
    mode_s = m;
    src_s  = s;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) step_s(M_SHIFT, 4'b1111);
    total++;
    if (dst_valid_s !== 1'b1) begin
      bad++;
      $display("FAIL reset_preload_valid: got %b want 1", dst_valid_s);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (fill_s !== 3'd0 || full_s !== 1'b0 || dst_s !== 6'd0 || dst_valid_s !== 1'b0) begin
      bad++;
      $display("FAIL reset_async_small: fill=%0d full=%b dst=%0d valid=%b want all 0",
               fill_s, full_s, dst_s, dst_valid_s);
    end
    total++;
    if (fill_d !== 5'd0 || full_d !== 1'b0 || dst_d !== 36'd0 || dst_valid_d !== 1'b0) begin
      bad++;
      $display("FAIL reset_async_big: fill=%0d full=%b dst=%0d valid=%b want all 0",
               fill_d, full_d, dst_d, dst_valid_d);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    step_s(M_SHIFT, 4'b0000);
    total++;
    if (fill_s !== 3'd1) begin
      bad++;
      $display("FAIL reset_first_shift_fill: got %0d want 1", fill_s);
    end
  endtask

  task automatic test_fill();
    int want_dst;
    step_s(M_CLEAR, 4'b0000);
    for (int i = 1; i <= 4; i++) begin
      step_s(M_SHIFT, 4'b1111);
      total++;
      if (fill_s !== 3'(i) || full_s !== (i == 4) || dst_valid_s !== 1'b0) begin
        bad++;
        $display("FAIL fill_step%0d: fill=%0d full=%b valid=%b want fill=%0d full=%b valid=0",
                 i, fill_s, full_s, dst_valid_s, i, (i == 4));
      end
    end
    step_s(M_HOLD, 4'b0000);
    want_dst = 4 * ((1 << 4) - 1);
    total++;
    if (dst_valid_s !== 1'b1 || dst_s !== 6'(want_dst)) begin
      bad++;
      $display("FAIL fill_dst: dst=%0d valid=%b want dst=%0d valid=1", dst_s, dst_valid_s, want_dst);
    end
  endtask

  task automatic test_saturation();
    logic b[10];
    int want;
    step_s(M_CLEAR, 4'b0000);
    for (int i = 0; i < 6; i++) b[i] = 1'($urandom_range(0, 1));
    b[6] = 1'b1; b[7] = 1'b0; b[8] = 1'b1; b[9] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step_s(M_SHIFT, {3'b000, b[i]});
      total++;
      if (fill_s !== 3'((i + 1 < 4) ? i + 1 : 4)) begin
        bad++;
        $display("FAIL sat_fill%0d: got %0d want %0d", i, fill_s, (i + 1 < 4) ? i + 1 : 4);
      end
    end
    step_s(M_HOLD, 4'b0000);
    want = 4'b1011;
    total++;
    if (dst_s !== 6'(want)) begin
      bad++;
      $display("FAIL sat_window: got %0d want %0d", dst_s, want);
    end
  endtask

  task automatic test_rotate();
    step_s(M_CLEAR, 4'b0000);
    step_s(M_SHIFT, 4'b0001);
    for (int i = 0; i < 3; i++) step_s(M_SHIFT, 4'b0000);
    step_s(M_HOLD, 4'b0000);
    total++;
    if (dst_s !== 6'd8) begin
      bad++;
      $display("FAIL rot_load: got %0d want 8", dst_s);
    end
    step_s(M_ROTATE, 4'b1111);
    step_s(M_HOLD, 4'b0000);
    total++;
    if (dst_s !== 6'd1 || fill_s !== 3'd4) begin
      bad++;
      $display("FAIL rot_once: dst=%0d fill=%0d want dst=1 fill=4", dst_s, fill_s);
    end
    for (int i = 0; i < 3; i++) begin
      step_s(M_ROTATE, 4'b1111);
      total++;
      if (fill_s !== 3'd4) begin
        bad++;
        $display("FAIL rot_fill%0d: got %0d want 4", i, fill_s);
      end
    end
    step_s(M_HOLD, 4'b0000);
    total++;
    if (dst_s !== 6'd8) begin
      bad++;
      $display("FAIL rot_full_turn: got %0d want 8", dst_s);
    end
  endtask

  task automatic test_clear_while_full();
    for (int i = 0; i < 4; i++) step_s(M_SHIFT, 4'b1111);
    step_s(M_HOLD, 4'b0000);
    total++;
    if (full_s !== 1'b1 || dst_valid_s !== 1'b1) begin
      bad++;
      $display("FAIL clr_pre: full=%b valid=%b want 1 1", full_s, dst_valid_s);
    end
    step_s(M_CLEAR, 4'b1111);
    total++;
    if (fill_s !== 3'd0 || full_s !== 1'b0 || dst_valid_s !== 1'b0) begin
      bad++;
      $display("FAIL clr_edge: fill=%0d full=%b valid=%b want 0 0 0", fill_s, full_s, dst_valid_s);
    end
    step_s(M_HOLD, 4'b0000);
    total++;
    if (dst_s !== 6'd0 || dst_valid_s !== 1'b0) begin
      bad++;
      $display("FAIL clr_dst: dst=%0d valid=%b want 0 0", dst_s, dst_valid_s);
    end
  endtask

  // random traffic on the 31x31 instance, scoreboarded against word arithmetic
  task automatic test_random();
    longint unsigned w[31];
    longint unsigned mask;
    longint unsigned sum;
    int m_fill;
    int r;
    logic [1:0] m;
    logic [30:0] s;
    logic [36:0] exp;
    mask = (64'd1 << 31) - 1;
    mode_s = M_HOLD;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    foreach (w[c]) w[c] = 0;
    m_fill = 0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      r = $urandom_range(0, 99);
      m = (r < 60) ? M_SHIFT : (r < 80) ? M_ROTATE : (r < 97) ? M_HOLD : M_CLEAR;
      s = 31'($urandom);
      mode_d = m;
      src_d  = s;
      sum = 0;
      foreach (w[c]) sum += w[c];
      exp_q.push_back({(m_fill == 31) && (m != M_CLEAR), 36'(sum)});
      foreach (w[c]) begin
        case (m)
          M_SHIFT:  w[c] = ((w[c] << 1) | longint'(s[c])) & mask;
          M_ROTATE: w[c] = ((w[c] << 1) | (w[c] >> 30)) & mask;
          M_CLEAR:  w[c] = 0;
          default:  w[c] = w[c];
        endcase
      end
      if (m == M_SHIFT && m_fill < 31) m_fill++;
      if (m == M_CLEAR) m_fill = 0;
      @(posedge clk);
      #1;
      exp = exp_q.pop_front();
      total++;
      if (dst_d !== exp[35:0] || dst_valid_d !== exp[36] || fill_d !== 5'(m_fill)) begin
        bad++;
        $display("FAIL rand_cyc%0d: dst=%0d valid=%b fill=%0d want dst=%0d valid=%b fill=%0d",
                 cyc, dst_d, dst_valid_d, fill_d, exp[35:0], exp[36], m_fill);
      end
    end
    mode_d = M_HOLD;
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_fill();
    test_saturation();
    test_rotate();
    test_clear_while_full();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
